// File: rtl/sram_burst_ctrl_if.sv
// Burst command, write-stream and read-stream handshakes between a layer
// sequencer (master) and the scratch SRAM burst controller (slave).
interface sram_burst_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH:0]   cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, done
  );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Burst initiator for the single-port scratch SRAM: streams write bursts in and
// read bursts out, hiding the one-cycle read latency behind a 2-entry FIFO.
module sram_burst_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_burst_ctrl_if.slave      bus,
  output logic                  mem_en_n,
  output logic                  mem_wren_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  pending;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            count;
  logic                  done_q;

  logic                  pop, wr_fire, issue, rd_last;
  logic [2:0]            occ;

  // Occupancy counts stored words plus the one in flight, net of this cycle's pop,
  // so a new read is only issued when its data is guaranteed a FIFO slot.
  always_comb begin
    pop     = (count != 2'd0) && bus.rd_ready;
    wr_fire = (state == WRITE) && bus.wr_valid;
    occ     = 3'(count) + 3'(pending) - 3'(pop);
    issue   = (state == READ) && (remaining != '0) && (occ < 3'd2);
    rd_last = (state == READ) && (remaining == '0) && !pending && (count == 2'd1) && pop;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid && (bus.cmd_len != '0))
                 state_nxt = bus.cmd_write ? WRITE : READ;
      WRITE:   if (wr_fire && (remaining == (ADDR_WIDTH+1)'(1))) state_nxt = IDLE;
      READ:    if (rd_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state == IDLE);
    bus.wr_ready  = (state == WRITE);
    bus.rd_valid  = (count != 2'd0);
    bus.rd_data   = fifo_mem[rd_ptr];
    bus.done      = done_q;
    mem_en_n      = !(wr_fire || issue);
    mem_wren_n    = !wr_fire;
    mem_addr      = cur_addr;
    mem_wdata     = bus.wr_data;
  end

  // A zero-length command completes immediately without touching the SRAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      pending   <= 1'b0;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pending <= issue;
      done_q  <= ((state == IDLE) && bus.cmd_valid && (bus.cmd_len == '0)) ||
                 (wr_fire && (remaining == (ADDR_WIDTH+1)'(1))) ||
                 rd_last;
      if ((state == IDLE) && bus.cmd_valid) begin
        cur_addr  <= bus.cmd_addr;
        remaining <= bus.cmd_len;
      end else if (wr_fire || issue) begin
        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end
      if (pending) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      count <= count + 2'(pending) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (pending) fifo_mem[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl against a behavioural registered-read SRAM.
module tb_sram_burst_ctrl;
  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_en_n, mem_wren_n;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] sram [32] = '{default: '0};
  logic [DW-1:0] exp_mem [32];
  int            checks = 0;
  int            errors = 0;

  sram_burst_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_en_n  (mem_en_n),
    .mem_wren_n(mem_wren_n),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_en_n) begin
      if (!mem_wren_n) sram[mem_addr] <= mem_wdata;
      else             mem_rdata      <= sram[mem_addr];
    end
  end

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready);
    end
    checks++;
    if ({bus.rd_valid, bus.done, bus.wr_ready} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_outputs: got rd_valid/done/wr_ready=%b%b%b expected 000",
                         bus.rd_valid, bus.done, bus.wr_ready);
    end
    checks++;
    if ({mem_en_n, mem_wren_n} !== 2'b11) begin
      errors++; $display("[TB] FAIL reset_mem_ctrl: got en_n/wren_n=%b%b expected 11", mem_en_n, mem_wren_n);
    end
  endtask

  task automatic test_write(input string name, input logic [AW-1:0] addr, input int len,
                            input logic [DW-1:0] base, input logic [7:0] vpat);
    int            hs = 0, cyc = 0, last_wr = -1, done_cnt = 0, done_cyc = -1;
    logic [AW-1:0] a;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = addr;
    bus.cmd_len = (AW+1)'(len); bus.wr_valid = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, mem_en_n} !== 2'b11) begin
      errors++; $display("[TB] FAIL %s cmd_accept: got cmd_ready/en_n=%b%b expected 11", name, bus.cmd_ready, mem_en_n);
    end
    while (!(hs == len && cyc >= last_wr + 3) && cyc < 100) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.wr_valid  = (hs < len) ? vpat[cyc % 8] : 1'b0;
      bus.wr_data   = base + DW'(hs);
      #1;
      a = addr + AW'(hs);
      if (bus.wr_valid) begin
        checks++;
        if ({bus.wr_ready, mem_en_n, mem_wren_n, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b0, a, bus.wr_data}) begin
          errors++; $display("[TB] FAIL %s write%0d: got rdy/en_n/wren_n=%b%b%b addr=%0d data=%h expected 100 addr=%0d data=%h",
                             name, hs, bus.wr_ready, mem_en_n, mem_wren_n, mem_addr, mem_wdata, a, bus.wr_data);
        end
        exp_mem[a] = bus.wr_data;
        hs++;
        last_wr = cyc;
      end else begin
        checks++;
        if (mem_en_n !== 1'b1) begin
          errors++; $display("[TB] FAIL %s idle_cycle%0d: got en_n=%b expected 1", name, cyc, mem_en_n);
        end
      end
      if (bus.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      cyc++;
    end
    checks++;
    if (hs != len) begin
      errors++; $display("[TB] FAIL %s timeout: got %0d writes expected %0d", name, hs, len);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_wr + 1) begin
      errors++; $display("[TB] FAIL %s done: got %0d pulses at cycle %0d expected 1 at cycle %0d",
                         name, done_cnt, done_cyc, last_wr + 1);
    end
  endtask

  task automatic test_read(input string name, input logic [AW-1:0] addr, input int len,
                           input logic [3:0] rpat, input bit tight);
    int            cyc = 0, issues = 0, pops = 0, over = 0, wbad = 0, done_cnt = 0, done_cyc = -1;
    int            first_iss = -1, last_iss = -1, first_val = -1, first_pop = -1, last_pop = -1;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] a;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = addr;
    bus.cmd_len = (AW+1)'(len); bus.rd_ready = 1'b0; bus.wr_valid = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, mem_en_n} !== 2'b11) begin
      errors++; $display("[TB] FAIL %s cmd_accept: got cmd_ready/en_n=%b%b expected 11", name, bus.cmd_ready, mem_en_n);
    end
    while (!(pops == len && cyc >= last_pop + 3) && cyc < 200) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.rd_ready  = rpat[cyc % 4];
      #1;
      if (mem_en_n === 1'b0) begin
        issues++;
        if (first_iss < 0) first_iss = cyc;
        last_iss = cyc;
        if (mem_wren_n !== 1'b1) wbad++;
      end
      if (bus.rd_valid === 1'b1 && first_val < 0) first_val = cyc;
      if (prev_stall) begin
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== prev_data) begin
          errors++; $display("[TB] FAIL %s stall_hold%0d: got valid=%b data=%h expected valid=1 data=%h",
                             name, cyc, bus.rd_valid, bus.rd_data, prev_data);
        end
      end
      if (bus.rd_valid === 1'b1 && bus.rd_ready) begin
        a = addr + AW'(pops);
        checks++;
        if (bus.rd_data !== exp_mem[a]) begin
          errors++; $display("[TB] FAIL %s word%0d: got %h expected %h", name, pops, bus.rd_data, exp_mem[a]);
        end
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (issues - pops > 2) over++;
      if (bus.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      prev_stall = (bus.rd_valid === 1'b1) && !bus.rd_ready;
      prev_data  = bus.rd_data;
      cyc++;
    end
    checks++;
    if (pops != len || issues != len) begin
      errors++; $display("[TB] FAIL %s counts: got %0d pops %0d issues expected %0d each", name, pops, issues, len);
    end
    checks++;
    if (wbad != 0 || over != 0) begin
      errors++; $display("[TB] FAIL %s integrity: got %0d write-enables %0d overfills expected 0 and 0", name, wbad, over);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_pop + 1) begin
      errors++; $display("[TB] FAIL %s done: got %0d pulses at cycle %0d expected 1 at cycle %0d",
                         name, done_cnt, done_cyc, last_pop + 1);
    end
    if (tight) begin
      checks++;
      if (first_val != first_iss + 2 || last_iss - first_iss != len - 1 || last_pop - first_pop != len - 1) begin
        errors++; $display("[TB] FAIL %s timing: got first_iss=%0d first_val=%0d issue_span=%0d pop_span=%0d expected first_val=%0d spans=%0d",
                           name, first_iss, first_val, last_iss - first_iss, last_pop - first_pop, first_iss + 2, len - 1);
      end
    end
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 5'd9; bus.cmd_len = '0;
    #1;
    checks++;
    if ({bus.cmd_ready, mem_en_n} !== 2'b11) begin
      errors++; $display("[TB] FAIL len0_accept: got cmd_ready/en_n=%b%b expected 11", bus.cmd_ready, mem_en_n);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    checks++;
    if ({bus.done, bus.cmd_ready, mem_en_n} !== 3'b111) begin
      errors++; $display("[TB] FAIL len0_done: got done/cmd_ready/en_n=%b%b%b expected 111", bus.done, bus.cmd_ready, mem_en_n);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.done, mem_en_n} !== 2'b01) begin
      errors++; $display("[TB] FAIL len0_after: got done/en_n=%b%b expected 01", bus.done, mem_en_n);
    end
  endtask

  task automatic test_reset_mid_read();
    int pops = 0, cyc = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 5'd3; bus.cmd_len = 6'd5;
    bus.rd_ready = 1'b0;
    while (pops < 2 && cyc < 50) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.rd_ready  = 1'b1;
      #1;
      if (bus.rd_valid === 1'b1) pops++;
      cyc++;
    end
    checks++;
    if (pops != 2) begin
      errors++; $display("[TB] FAIL midread_pops: got %0d expected 2", pops);
    end
    @(negedge clk);
    rst = 1'b1; bus.rd_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.rd_valid, mem_en_n, bus.done, bus.wr_ready} !== 5'b10100) begin
      errors++; $display("[TB] FAIL midread_reset: got rdy/rd_valid/en_n/done/wr_ready=%b%b%b%b%b expected 10100",
                         bus.cmd_ready, bus.rd_valid, mem_en_n, bus.done, bus.wr_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus.rd_valid, mem_en_n, bus.done} !== 3'b010) begin
        errors++; $display("[TB] FAIL midread_quiet%0d: got rd_valid/en_n/done=%b%b%b expected 010",
                           i, bus.rd_valid, mem_en_n, bus.done);
      end
    end
    test_read("post_reset_read", 5'd4, 1, 4'hF, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid  = 1'b0; bus.wr_data   = '0;   bus.rd_ready = 1'b0;
    $display("[TB] starting sram_burst_ctrl directed tests");
    test_reset();
    test_write("burst_write", 5'd3, 4, 16'hA000, 8'hFF);
    test_read("burst_read", 5'd3, 4, 4'hF, 1'b1);
    test_write("wrap_write", 5'd30, 4, 16'hB000, 8'hFF);
    test_read("wrap_read", 5'd30, 4, 4'hF, 1'b1);
    test_read("backpressure_read", 5'd30, 6, 4'b1001, 1'b0);
    test_write("gap_write", 5'd10, 3, 16'hC000, 8'b0001_0101);
    test_read("gap_read", 5'd10, 3, 4'hF, 1'b1);
    test_len_zero();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
